// File: rtl/vga_console_pkg.sv
// Shared constants for the text-console pixel renderer: palette, attribute
// field layout and colour width.
package vga_console_pkg;

    localparam int RGB_W     = 12;
    localparam int FG_LSB    = 0;
    localparam int BG_LSB    = 4;
    localparam int BLINK_BIT = 7;

    typedef logic [RGB_W-1:0] rgb_t;

    // CGA-style 16-colour table, entry 0 in the least significant slot.
    localparam logic [15:0][RGB_W-1:0] PALETTE = {
        12'hFFF,  // 15 white
        12'hFF5,  // 14 yellow
        12'hF5F,  // 13 light magenta
        12'hF55,  // 12 light red
        12'h5FF,  // 11 light cyan
        12'h5F5,  // 10 light green
        12'h55F,  //  9 light blue
        12'h555,  //  8 dark grey
        12'hAAA,  //  7 light grey
        12'hA50,  //  6 brown
        12'hA0A,  //  5 magenta
        12'hA00,  //  4 red
        12'h0AA,  //  3 cyan
        12'h0A0,  //  2 green
        12'h00A,  //  1 blue
        12'h000   //  0 black
    };

    function automatic rgb_t palette_lookup(input logic [3:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_console_blink.sv
// Frame counter that toggles the cursor/character blink phase every
// BLINK_FRAMES frame_start pulses. Phase 0 means "visible".
module vga_console_blink #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic pixel_clk,
    input  logic reset_n,
    input  logic frame_start,
    output logic blink_phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // Advance the frame count; wrap and flip the phase on the last frame.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_start) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and phase registers.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase = phase_q;

endmodule

// File: rtl/vga_console_render.sv
// Text-console pixel stage: fetches character code/attribute and glyph row,
// picks the pixel, applies palette, blink and underline cursor, and emits
// registered RGB with the VGA timing delayed to match.
module vga_console_render
    import vga_console_pkg::*;
#(
    parameter int TEXT_COLUMNS     = 10,
    parameter int TEXT_ROWS        = 5,
    parameter int GLYPH_COLUMNS    = 9,
    parameter int GLYPH_ROWS       = 14,
    parameter int CODE_WIDTH       = 8,
    parameter int CURSOR_START_ROW = 12,
    parameter int BLINK_FRAMES     = 16,
    parameter int SYNC_ACTIVE_LOW  = 1,
    localparam int ADDR_W = $clog2(TEXT_COLUMNS * TEXT_ROWS),
    localparam int ROW_W  = $clog2(GLYPH_ROWS),
    localparam int COL_W  = $clog2(GLYPH_COLUMNS)
) (
    input  logic                    pixel_clk,
    input  logic                    reset_n,
    input  logic                    frame_start,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    de_in,
    input  logic [ADDR_W-1:0]       char_address,
    input  logic [ROW_W-1:0]        glyph_row,
    input  logic [COL_W-1:0]        glyph_column,
    input  logic                    idle,
    input  logic                    cursor_enable,
    input  logic [ADDR_W-1:0]       cursor_address,
    output logic [ADDR_W-1:0]       char_ram_address,
    input  logic [CODE_WIDTH+7:0]   char_ram_data,
    output logic [CODE_WIDTH+ROW_W-1:0] font_address,
    input  logic [GLYPH_COLUMNS-1:0] font_data,
    output logic [RGB_W-1:0]        rgb,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    de_out
);

    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic blink_phase;

    vga_console_blink #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .pixel_clk  (pixel_clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .blink_phase(blink_phase)
    );

    // ---------------- S0: character RAM address, cursor hit ----------------
    logic cursor_hit_s0;

    assign char_ram_address = char_address;
    assign cursor_hit_s0 = cursor_enable & ~blink_phase
                         & (char_address == cursor_address)
                         & (glyph_row >= ROW_W'(CURSOR_START_ROW));

    logic [ROW_W-1:0] row_s1_q;
    logic [COL_W-1:0] col_s1_q;
    logic             idle_s1_q;
    logic             hit_s1_q;

    // Carry glyph position and flags alongside the character RAM read.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            row_s1_q  <= '0;
            col_s1_q  <= '0;
            idle_s1_q <= 1'b0;
            hit_s1_q  <= 1'b0;
        end else begin
            row_s1_q  <= glyph_row;
            col_s1_q  <= glyph_column;
            idle_s1_q <= idle;
            hit_s1_q  <= cursor_hit_s0;
        end
    end

    // ---------------- S1: font ROM address ----------------
    assign font_address = {char_ram_data[CODE_WIDTH-1:0], row_s1_q};

    logic [7:0]       attr_s2_q;
    logic [COL_W-1:0] col_s2_q;
    logic             idle_s2_q;
    logic             hit_s2_q;

    // Carry attribute and flags alongside the font ROM read.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            attr_s2_q <= '0;
            col_s2_q  <= '0;
            idle_s2_q <= 1'b0;
            hit_s2_q  <= 1'b0;
        end else begin
            attr_s2_q <= char_ram_data[CODE_WIDTH+7:CODE_WIDTH];
            col_s2_q  <= col_s1_q;
            idle_s2_q <= idle_s1_q;
            hit_s2_q  <= hit_s1_q;
        end
    end

    // ---------------- S2: pixel select, colour, forced black ----------------
    // Bitmap MSB is the leftmost column; reverse it so the column indexes directly.
    logic [GLYPH_COLUMNS-1:0] font_rev;

    for (genvar gi = 0; gi < GLYPH_COLUMNS; gi++) begin : g_font_rev
        assign font_rev[gi] = font_data[GLYPH_COLUMNS-1-gi];
    end

    logic [3:0] de_q, hs_q, vs_q;
    logic       pix_raw;
    logic       pix;
    logic       fg_sel;
    rgb_t       colour;
    rgb_t       rgb_d;
    rgb_t       rgb_q;

    // Pick the glyph pixel, apply blink/cursor, look up colour, blank if inactive.
    always_comb begin
        pix_raw = 1'b0;
        if ({1'b0, col_s2_q} < (COL_W+1)'(GLYPH_COLUMNS)) begin
            pix_raw = font_rev[col_s2_q];
        end
        pix    = pix_raw & ~(attr_s2_q[BLINK_BIT] & blink_phase);
        fg_sel = pix ^ hit_s2_q;
        if (fg_sel) begin
            colour = palette_lookup(attr_s2_q[FG_LSB +: 4]);
        end else begin
            colour = palette_lookup({1'b0, attr_s2_q[BG_LSB +: 3]});
        end
        rgb_d = colour;
        // de_q[2] is the timing that will accompany this pixel at the output.
        if (idle_s2_q || !de_q[2]) begin
            rgb_d = '0;
        end
    end

    // Output colour register.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    // Four-deep timing delay: one cycle for the sync stage plus three here.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            de_q <= '0;
            hs_q <= {4{SYNC_IDLE}};
            vs_q <= {4{SYNC_IDLE}};
        end else begin
            de_q <= {de_q[2:0], de_in};
            hs_q <= {hs_q[2:0], hsync_in};
            vs_q <= {vs_q[2:0], vsync_in};
        end
    end

    assign rgb       = rgb_q;
    assign de_out    = de_q[3];
    assign hsync_out = hs_q[3];
    assign vsync_out = vs_q[3];

endmodule

// File: tb/tb_vga_console_render.sv
// Directed bench for vga_console_render with behavioural character RAM and
// font ROM (both registered, one cycle of read latency).
module tb_vga_console_render;

    logic        pixel_clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic        hsync_in, vsync_in, de_in;
    logic [5:0]  char_address;
    logic [3:0]  glyph_row;
    logic [3:0]  glyph_column;
    logic        idle;
    logic        cursor_enable;
    logic [5:0]  cursor_address;
    logic [5:0]  char_ram_address;
    logic [15:0] char_ram_data;
    logic [11:0] font_address;
    logic [8:0]  font_data;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, de_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [3:0]  row;
        logic [3:0]  col;
        logic [11:0] exp;
    } vec_t;

    vga_console_render dut (
        .pixel_clk       (pixel_clk),
        .reset_n         (reset_n),
        .frame_start     (frame_start),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .de_in           (de_in),
        .char_address    (char_address),
        .glyph_row       (glyph_row),
        .glyph_column    (glyph_column),
        .idle            (idle),
        .cursor_enable   (cursor_enable),
        .cursor_address  (cursor_address),
        .char_ram_address(char_ram_address),
        .char_ram_data   (char_ram_data),
        .font_address    (font_address),
        .font_data       (font_data),
        .rgb             (rgb),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .de_out          (de_out)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Screen contents: cell 3 'A' white on blue, cell 5 blinking 'A', rest blank green.
    function automatic logic [15:0] char_word(input logic [5:0] a);
        case (a)
            6'd3:    return 16'h1F41;
            6'd5:    return 16'h9F41;
            default: return 16'h2E20;
        endcase
    endfunction

    always @(posedge pixel_clk) char_ram_data <= char_word(char_ram_address);
    always @(posedge pixel_clk)
        font_data <= (font_address[11:4] == 8'h41) ? 9'b1_0000_0001 : 9'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        char_address = v.addr;
        glyph_row    = v.row;
        glyph_column = v.col;
        tick(); tick(); tick();
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; frame_start = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        de_in = 1'b0; idle = 1'b0; cursor_enable = 1'b0; cursor_address = 6'd0;
        char_address = 6'd3; glyph_row = 4'd0; glyph_column = 4'd0;
        tick(); tick();
        checks++;
        if (rgb !== 12'h000 || de_out !== 1'b0 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: rgb=%h de=%b hs=%b vs=%b expected 000 0 1 1",
                     rgb, de_out, hsync_out, vsync_out);
        end
        reset_n = 1'b1;
        tick(); tick(); tick(); tick();
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL de_low_black: rgb=%h expected 000", rgb);
        end
        de_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (de_out !== (i == 4) || rgb !== ((i == 4) ? 12'hFFF : 12'h000)) begin
                errors++;
                $display("FAIL de_latency_%0d: de_out=%b rgb=%h expected %b %h", i, de_out, rgb,
                         (i == 4), (i == 4) ? 12'hFFF : 12'h000);
            end
        end
        $display("reset: de_out=%b rgb=%h hs=%b", de_out, rgb, hsync_out);
    endtask

    task automatic test_fetch();
        vec_t v [5];
        v = '{ '{6'd3, 4'd2, 4'd0, 12'hFFF},   // leftmost column set -> fg white
               '{6'd3, 4'd2, 4'd4, 12'h00A},   // middle column clear -> bg blue
               '{6'd3, 4'd2, 4'd8, 12'hFFF},   // rightmost column set
               '{6'd3, 4'd2, 4'd9, 12'h00A},   // out of range column -> pix 0
               '{6'd4, 4'd2, 4'd0, 12'h0A0} }; // blank cell -> bg green
        char_address = 6'd3; glyph_row = 4'd5; glyph_column = 4'd0;
        #1;
        checks++;
        if (char_ram_address !== 6'd3) begin
            errors++;
            $display("FAIL char_ram_address: got %0d expected 3", char_ram_address);
        end
        tick();
        checks++;
        if (font_address !== {8'h41, 4'd5}) begin
            errors++;
            $display("FAIL font_address: got %h expected %h", font_address, {8'h41, 4'd5});
        end
        for (int i = 0; i < 5; i++) begin
            apply(v[i]);
            checks++;
            if (rgb !== v[i].exp) begin
                errors++;
                $display("FAIL fetch_%0d: rgb=%h expected %h", i, rgb, v[i].exp);
            end
            $display("fetch addr=%0d col=%0d rgb=%h", v[i].addr, v[i].col, rgb);
        end
    endtask

    task automatic test_idle();
        apply('{6'd3, 4'd0, 4'd0, 12'hFFF});
        idle = 1'b1;
        tick();
        idle = 1'b0;
        tick();
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL idle_before: rgb=%h expected fff", rgb);
        end
        tick();
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL idle_at_t3: rgb=%h expected 000", rgb);
        end
        tick();
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL idle_after: rgb=%h expected fff", rgb);
        end
        $display("idle: one-pixel blank checked");
    endtask

    task automatic test_sync_delay();
        hsync_in = 1'b0; vsync_in = 1'b0;
        tick();
        hsync_in = 1'b1; vsync_in = 1'b1;
        tick(); tick();
        checks++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            errors++;
            $display("FAIL sync_early: hs=%b vs=%b expected 1 1", hsync_out, vsync_out);
        end
        tick();
        checks++;
        if (hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
            errors++;
            $display("FAIL sync_at_4: hs=%b vs=%b expected 0 0", hsync_out, vsync_out);
        end
        tick();
        checks++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            errors++;
            $display("FAIL sync_after: hs=%b vs=%b expected 1 1", hsync_out, vsync_out);
        end
        $display("sync: 4-cycle delay checked");
    endtask

    task automatic test_cursor();
        vec_t v [5];
        v = '{ '{6'd3, 4'd12, 4'd4, 12'hFFF},   // first cursor row, pix 0 -> fg
               '{6'd3, 4'd11, 4'd4, 12'h00A},   // row above cursor -> bg
               '{6'd3, 4'd12, 4'd0, 12'h00A},   // cursor XOR lit pixel -> bg
               '{6'd3, 4'd13, 4'd4, 12'hFFF},   // last glyph row still cursor
               '{6'd4, 4'd12, 4'd4, 12'h0A0} }; // other cell unaffected
        cursor_enable = 1'b1; cursor_address = 6'd3;
        for (int i = 0; i < 5; i++) begin
            apply(v[i]);
            checks++;
            if (rgb !== v[i].exp) begin
                errors++;
                $display("FAIL cursor_%0d: rgb=%h expected %h", i, rgb, v[i].exp);
            end
            $display("cursor addr=%0d row=%0d col=%0d rgb=%h", v[i].addr, v[i].row, v[i].col, rgb);
        end
        cursor_enable = 1'b0;
        apply('{6'd3, 4'd12, 4'd4, 12'h00A});
        checks++;
        if (rgb !== 12'h00A) begin
            errors++;
            $display("FAIL cursor_disabled: rgb=%h expected 00a", rgb);
        end
    endtask

    task automatic test_blink();
        cursor_enable = 1'b1; cursor_address = 6'd3;
        char_address = 6'd3; glyph_row = 4'd12; glyph_column = 4'd4;
        pulse_frames(16);
        apply('{6'd3, 4'd12, 4'd4, 12'h00A});
        checks++;
        if (rgb !== 12'h00A) begin
            errors++;
            $display("FAIL blink_cursor_hidden: rgb=%h expected 00a", rgb);
        end
        apply('{6'd5, 4'd0, 4'd0, 12'h00A});
        checks++;
        if (rgb !== 12'h00A) begin
            errors++;
            $display("FAIL blink_char_hidden: rgb=%h expected 00a", rgb);
        end
        apply('{6'd3, 4'd0, 4'd0, 12'hFFF});
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL blink_plain_char: rgb=%h expected fff", rgb);
        end
        apply('{6'd3, 4'd12, 4'd4, 12'h00A});
        pulse_frames(15);
        tick(); tick(); tick();
        checks++;
        if (rgb !== 12'h00A) begin
            errors++;
            $display("FAIL blink_frame31: rgb=%h expected 00a", rgb);
        end
        // 32nd pulse: the pixel in the wrap cycle still sees the old phase.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick(); tick();
        checks++;
        if (rgb !== 12'h00A) begin
            errors++;
            $display("FAIL blink_wrap_cycle: rgb=%h expected 00a", rgb);
        end
        tick();
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL blink_restored: rgb=%h expected fff", rgb);
        end
        apply('{6'd5, 4'd0, 4'd0, 12'hFFF});
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL blink_char_shown: rgb=%h expected fff", rgb);
        end
        cursor_enable = 1'b0;
        $display("blink: phase toggles at frames 16 and 32 checked");
    endtask

    task automatic test_async_reset();
        hsync_in = 1'b0; vsync_in = 1'b0;
        apply('{6'd3, 4'd0, 4'd0, 12'hFFF});
        tick(); tick();
        checks++;
        if (rgb !== 12'hFFF || hsync_out !== 1'b0 || de_out !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: rgb=%h hs=%b de=%b expected fff 0 1", rgb, hsync_out, de_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rgb !== 12'h000 || de_out !== 1'b0 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: rgb=%h de=%b hs=%b vs=%b expected 000 0 1 1",
                     rgb, de_out, hsync_out, vsync_out);
        end
        $display("async reset: rgb=%h de=%b hs=%b", rgb, de_out, hsync_out);
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_idle();
        test_sync_delay();
        test_cursor();
        test_blink();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_console_render.md
Name: vga_console_render

Overview:
- Pixel-generation stage directly downstream of the console sync/address generator.
- Consumes char_address, glyph_row, glyph_column and idle; reads character RAM (code + attribute) and font ROM (one bitmap row); selects the pixel, applies colour attributes and a blinking cursor; emits registered 12-bit RGB.
- Delays the raw VGA hsync/vsync/de so they stay aligned with RGB.

Parameters:
- TEXT_COLUMNS, 10, characters per text line
- TEXT_ROWS, 5, text lines per frame
- GLYPH_COLUMNS, 9, glyph bitmap width in pixels
- GLYPH_ROWS, 14, glyph bitmap height in pixels
- CODE_WIDTH, 8, character code bits
- CURSOR_START_ROW, 12, first glyph row painted by the cursor (underline cursor)
- BLINK_FRAMES, 16, frames per cursor blink half-period
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync idle high
- Derived, not overridable: ADDR_W = $clog2(TEXT_COLUMNS*TEXT_ROWS), ROW_W = $clog2(GLYPH_ROWS), COL_W = $clog2(GLYPH_COLUMNS)

Ports:
- pixel_clk  in  1  VGA pixel clock
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  first visible pixel of frame, same timing as the sync stage input
- hsync_in, vsync_in, de_in  in  1 each  raw VGA timing, aligned with frame_start
- char_address  in  ADDR_W  from sync stage, valid 1 cycle after timing
- glyph_row  in  ROW_W  from sync stage
- glyph_column  in  COL_W  from sync stage
- idle  in  1  from sync stage
- cursor_enable  in  1  cursor shown when 1
- cursor_address  in  ADDR_W  cursor character cell
- char_ram_address  out  ADDR_W  character RAM read address
- char_ram_data  in  CODE_WIDTH+8  {attr[7:0], code}, synchronous read, 1-cycle latency
- font_address  out  CODE_WIDTH+ROW_W  {code, glyph_row}
- font_data  in  GLYPH_COLUMNS  bitmap row, MSB = column 0 (leftmost), 1-cycle latency
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}
- hsync_out, vsync_out, de_out  out  1 each  timing aligned with rgb

Behaviour:
- Reset:
  - rgb = 0, de_out = 0.
  - hsync_out/vsync_out = SYNC_ACTIVE_LOW.
  - All pipeline registers 0; blink counter 0; blink phase 0 (cursor visible).
- Pipeline, with t = cycle of sync-stage outputs:
  - S0 (t): char_ram_address = char_address, combinational. Compute cursor_hit = cursor_enable & blink_phase==0 & char_address==cursor_address & glyph_row>=CURSOR_START_ROW. Register glyph_row, glyph_column, idle, cursor_hit.
  - S1 (t+1): font_address = {char_ram_data code, row_s1}, combinational. Register attr, column, idle, cursor_hit.
  - S2 (t+2): pix = font_data[GLYPH_COLUMNS-1-col_s2]. fg index = attr[3:0], bg index = attr[6:4]. cursor_hit XOR pix selects fg. rgb registered at t+3.
- Latency:
  - rgb is valid 3 cycles after the sync-stage outputs.
  - hsync/vsync/de are delayed by a 4-stage shift register, to absorb the sync stage's extra cycle.
- Forced black: rgb = 0 when idle_s2 = 1 or delayed de = 0. Idle and de dominate cursor and attribute.
- attr[7] = blink character: when set and blink_phase = 1, pix is forced to 0 (glyph hidden, background still shown).
- Palette: fixed 16-entry CGA-style table, index to 12-bit colour, combinational lookup in S2.
- Blink counter:
  - Increments on frame_start.
  - At BLINK_FRAMES-1 with frame_start: wraps to 0 and toggles blink_phase.
  - Counter width is $clog2(BLINK_FRAMES); BLINK_FRAMES = 1 toggles every frame.
- Simultaneous events: frame_start with counter wrap updates the phase on the next edge. S0 of that same cycle uses the old phase.
- Column index: col_s2 >= GLYPH_COLUMNS cannot occur from the sync stage; pix = 0 if it does.
- Reset mid-frame: pipeline flushes to black, syncs go to their idle level. Output resumes correctly once the sync stage restarts at the next frame_start.

Decomposition:
- Shared package vga_console_pkg:
  - 16-entry palette constant array
  - attribute field positions: FG_LSB = 0, BG_LSB = 4, BLINK_BIT = 7
  - rgb width constant 12
- Sub-module vga_console_blink: frame counter plus phase toggle, outputs blink_phase.
- Sync delay line is an inline shift register.

Test Plan:
- Reset then release: rgb = 0, hsync_out = vsync_out = 1, de_out = 0 until the 4th pixel_clk after de_in rises.
- char_address = 3 held: RAM returns code 0x41 with attr 0x1F at t+1 → font_address = {0x41, row}. font_data = 9'b1_0000_0001 gives column 0 → white 0xFFF and column 4 → blue palette[1] at t+3.
- idle = 1 for one cycle at t → rgb = 0 exactly at t+3, neighbouring pixels unaffected.
- cursor_address = 3, glyph_row = 12, font_data = 0 → rgb = fg colour. glyph_row = 11 → bg colour.
- 16 frame_start pulses → cursor suppressed for frames 16–31 and restored at frame 32. attr[7] = 1 glyph pixels become bg during the same frames.
- reset_n asserted while de_in = 1 → outputs immediately return to reset values, asynchronously and before the next pixel_clk edge.
